// File: rtl/fp_rsp_arb_pkg.sv
// Shared FPU types for the response-merge stage: the exception flag
// layout and a helper to merge flag vectors.
package fp_rsp_arb_pkg;

  localparam int FFLAGS_BITS = 5;

  // Exception flags, MSB first: invalid, div-by-zero, overflow, underflow, inexact.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic fflags_t fflags_merge(fflags_t a, fflags_t b);
    return fflags_t'(a | b);
  endfunction

endpackage

// File: rtl/fp_rsp_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer (wrapping) and moves the pointer past the winner on advance.
module fp_rsp_arb_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic [IDXW-1:0]     grant_idx,
  output logic                grant_vld
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  int              cand;

  // Search from ptr upward, wrapping; the first hit wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDXW'(cand);
      end
    end
    grant_oh = grant_vld ? (NUM_REQS'(1) << grant_idx) : '0;
  end

  // Pointer moves one past the winner only when its transfer happens.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld)
      ptr_d = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_rsp_arb.sv
// FPU response merge: round-robin over the execution cores into one
// registered stream, with lane flag reduction and a sticky flag register
// for the CSR unit.
module fp_rsp_arb
  import fp_rsp_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int LANES     = 1,
  parameter int TAGW      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CORES-1:0]               valid_in,
  output logic [NUM_CORES-1:0]               ready_in,
  input  logic [NUM_CORES*TAGW-1:0]          tag_in,
  input  logic [NUM_CORES*LANES*32-1:0]      result_in,
  input  logic [NUM_CORES-1:0]               has_fflags_in,
  input  logic [NUM_CORES*LANES*FFLAGS_BITS-1:0] fflags_in,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [TAGW-1:0]                    tag_out,
  output logic [LANES*32-1:0]                result_out,
  output logic                               has_fflags_out,
  output logic [FFLAGS_BITS-1:0]             fflags_out,
  input  logic                               clear_fflags,
  output logic [FFLAGS_BITS-1:0]             fflags_acc
);

  localparam int IDXW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] grant_oh;
  logic [IDXW-1:0]      grant_idx;
  logic                 grant_vld;
  logic                 enable;

  logic [TAGW-1:0]      tag_arr    [NUM_CORES];
  logic [LANES*32-1:0]  result_arr [NUM_CORES];
  fflags_t              red_arr    [NUM_CORES];

  logic                 valid_out_q, valid_out_d;
  logic [TAGW-1:0]      tag_out_q, tag_out_d;
  logic [LANES*32-1:0]  result_out_q, result_out_d;
  logic                 has_fflags_q, has_fflags_d;
  fflags_t              fflags_out_q, fflags_out_d;
  fflags_t              fflags_acc_q, fflags_acc_d;

  // The output stage can take a new response whenever it is empty or draining.
  assign enable   = ~valid_out_q | ready_out;
  assign ready_in = grant_oh & {NUM_CORES{enable}};

  fp_rsp_arb_rr_arbiter #(
    .NUM_REQS (NUM_CORES),
    .IDXW     (IDXW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (valid_in),
    .advance   (enable),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Unpack per-core payloads and reduce each core's lane flags up front so
  // the granted one is a single mux away from the register.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      tag_arr[c]    = tag_in[c*TAGW +: TAGW];
      result_arr[c] = result_in[c*LANES*32 +: LANES*32];
      red_arr[c]    = '0;
      if (has_fflags_in[c])
        for (int l = 0; l < LANES; l++)
          red_arr[c] = fflags_merge(red_arr[c],
                         fflags_t'(fflags_in[(c*LANES+l)*FFLAGS_BITS +: FFLAGS_BITS]));
    end
  end

  // Output register next-state; payload only reloads when a core is granted.
  always_comb begin
    valid_out_d  = valid_out_q;
    tag_out_d    = tag_out_q;
    result_out_d = result_out_q;
    has_fflags_d = has_fflags_q;
    fflags_out_d = fflags_out_q;
    if (enable) begin
      valid_out_d = |valid_in;
      if (grant_vld) begin
        tag_out_d    = tag_arr[grant_idx];
        result_out_d = result_arr[grant_idx];
        has_fflags_d = has_fflags_in[grant_idx];
        fflags_out_d = red_arr[grant_idx];
      end
    end
  end

  // Sticky flags: a clear coinciding with an emit keeps the emitted flags.
  always_comb begin
    fflags_acc_d = clear_fflags ? fflags_t'('0) : fflags_acc_q;
    if (valid_out_q && ready_out)
      fflags_acc_d = fflags_merge(fflags_acc_d, fflags_out_q);
  end

  // Output and accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_q  <= 1'b0;
      tag_out_q    <= '0;
      result_out_q <= '0;
      has_fflags_q <= 1'b0;
      fflags_out_q <= '0;
      fflags_acc_q <= '0;
    end else begin
      valid_out_q  <= valid_out_d;
      tag_out_q    <= tag_out_d;
      result_out_q <= result_out_d;
      has_fflags_q <= has_fflags_d;
      fflags_out_q <= fflags_out_d;
      fflags_acc_q <= fflags_acc_d;
    end
  end

  assign valid_out      = valid_out_q;
  assign tag_out        = tag_out_q;
  assign result_out     = result_out_q;
  assign has_fflags_out = has_fflags_q;
  assign fflags_out     = fflags_out_q;
  assign fflags_acc     = fflags_acc_q;

endmodule

// File: doc/fp_rsp_arb.md
Name: fp_rsp_arb

Overview:
- Response-side merge stage placed directly downstream of the FPU execution cores: non-compute, add/mul, div/sqrt and conversion.
- Round-robin arbitration over NUM_CORES valid/ready result streams, with a registered single output stream to the FPU commit path.
- Per-lane exception flags are reduced to one 5-bit value per response.
- Keeps a sticky accumulated-flags register for the CSR unit.

Parameters:
- NUM_CORES, 4, number of upstream FP cores (>=2).
- LANES, 1, SIMD lanes per response.
- TAGW, 1, tag width carried unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  NUM_CORES  per-core response valid
- ready_in  out  NUM_CORES  per-core accept
- tag_in  in  NUM_CORES*TAGW  per-core tag
- result_in  in  NUM_CORES*LANES*32  per-core lane results
- has_fflags_in  in  NUM_CORES  core response carries valid flags
- fflags_in  in  NUM_CORES*LANES*5  per-lane flags {NV,DZ,OF,UF,NX}
- valid_out  out  1  merged response valid
- ready_out  in  1  downstream accept
- tag_out  out  TAGW  tag of granted response
- result_out  out  LANES*32  results of granted response
- has_fflags_out  out  1  copy of granted has_fflags
- fflags_out  out  5  OR of granted lanes' flags; 0 when has_fflags is 0
- clear_fflags  in  1  clear sticky accumulator
- fflags_acc  out  5  sticky OR of all emitted fflags_out

Behaviour:
- Reset (async, active-high): valid_out=0, tag_out/result_out/has_fflags_out/fflags_out=0, fflags_acc=0, RR pointer=0.
- Output register empties or advances when `enable = ~valid_out | ready_out`.
- Grant selection:
  - Combinational round-robin among asserted valid_in bits.
  - Search starts at index ptr and wraps modulo NUM_CORES.
  - Exactly one or zero grants per cycle.
- Handshake:
  - ready_in[i] = (grant==i) & enable.
  - Transfer on input i when valid_in[i] & ready_in[i].
  - Non-granted cores see ready_in=0 and must hold their data stable.
- Output register, on enable:
  - valid_out <= any valid_in.
  - Payload fields load from the granted core.
  - If no valid_in, only valid_out clears; payload is don't-care.
- Latency: exactly 1 cycle from input transfer to valid_out; throughput 1 response/cycle with ready_out held high.
- Stall: while valid_out & ~ready_out, every output holds, all ready_in are 0, and ptr holds.
- Pointer update:
  - On a transfer from core g, ptr <= (g+1) mod NUM_CORES.
  - Otherwise ptr holds.
  - Wrap: g=NUM_CORES-1 gives ptr=0.
- Flag reduction: fflags_out = has_fflags ? OR over lanes of fflags_in[g][l] : 5'b0, computed before the register.
- Accumulator:
  - On the output transfer cycle (valid_out & ready_out): fflags_acc <= (clear_fflags ? 0 : fflags_acc) | fflags_out.
  - Otherwise, if clear_fflags: fflags_acc <= 0.
  - When clear and a transfer coincide, the new flags survive.
- Reset mid-stream drops any held response; cores re-present after reset, ptr=0.
- Tag and result pass through unmodified. The block does no reordering beyond arbitration order.

Decomposition:
- Shared FPU package supplies fflags_t (NV,DZ,OF,UF,NX) and FFLAGS_BITS=5.
- Natural sub-module: rr_arbiter (NUM_REQS parameter; inputs requests and an advance strobe; outputs one-hot grant, grant index and grant-valid; owns ptr).
- The output register is the existing pipe-register primitive: DEPTH=1, reset width 1 for valid.

Test Plan:
- Round-robin: NUM_CORES=4, all valid_in=4'b1111 held, ready_out=1 → output tags in order core0,1,2,3,0; exactly one ready_in per cycle.
- Backpressure: valid_out=1, ready_out=0 for 3 cycles with valid_in=4'b0110 → outputs stable, ready_in=0, ptr unchanged. Release → core1 then core2 emitted.
- Flag reduction: LANES=2, core1 lanes with fflags 5'b10000 and 5'b00001, has_fflags=1 → fflags_out=5'b10001. With has_fflags=0 → fflags_out=0.
- Sticky and clear: emit 5'b00100, then 5'b00010 → fflags_acc=5'b00110. Clear_fflags concurrent with emitting 5'b00001 → fflags_acc=5'b00001.
- Wrap and sparse: only core3 valid, then only core0 valid → both granted on consecutive cycles; ptr goes 0→0 after core3, then 1.
- Async reset mid-stall: assert reset between clock edges while valid_out=1 → valid_out and fflags_acc read 0 immediately; first grant after reset goes to the lowest valid index.
